// File: rtl/laser_pkg.sv
// Shared definitions for the two-centre laser coverage search: sizes,
// FSM state encoding, point storage format and a population-count helper.
package laser_pkg;

    // Coordinate width: points and centres live on a 16x16 grid
    localparam int DATA_W  = 4;
    // Points per pattern
    localparam int NPTS    = 40;
    // Squared coverage radius, inclusive
    localparam int R2      = 16;
    // Upper bound on search passes per pattern
    localparam int MAXPASS = 8;

    // Counter widths derived from the sizes above
    localparam int CNT_W   = 6;
    localparam int PASS_W  = 3;
    localparam int SCAN_W  = 2 * DATA_W;
    localparam int SCORE_W = 6;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } point_t;

    // Number of covered points in a coverage vector
    function automatic logic [SCORE_W-1:0] popcount(input logic [NPTS-1:0] v);
        logic [SCORE_W-1:0] n;
        n = '0;
        for (int i = 0; i < NPTS; i++) begin
            n = n + SCORE_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/laser_cover.sv
// Single point-in-circle test: does a laser centred at (cx,cy) reach (px,py)?
// Purely combinational; the top instantiates one per point per centre.
module laser_cover
    import laser_pkg::*;
(
    input  logic [DATA_W-1:0] cx,
    input  logic [DATA_W-1:0] cy,
    input  logic [DATA_W-1:0] px,
    input  logic [DATA_W-1:0] py,
    output logic              hit
);

    // Signed offsets span -15..15, so one extra bit over the coordinate width
    logic signed [DATA_W:0]   dx;
    logic signed [DATA_W:0]   dy;
    // Magnitudes fit back into the coordinate width (max 15)
    logic [DATA_W-1:0]        ax;
    logic [DATA_W-1:0]        ay;
    // Squares up to 225 and their sum up to 450
    logic [2*DATA_W-1:0]      sx;
    logic [2*DATA_W-1:0]      sy;
    logic [2*DATA_W:0]        d2;

    assign dx = $signed({1'b0, cx}) - $signed({1'b0, px});
    assign dy = $signed({1'b0, cy}) - $signed({1'b0, py});

    // Squaring the magnitude keeps the multiplier unsigned and narrow
    assign ax = dx[DATA_W] ? DATA_W'(-dx) : DATA_W'(dx);
    assign ay = dy[DATA_W] ? DATA_W'(-dy) : DATA_W'(dy);

    assign sx = {{DATA_W{1'b0}}, ax} * {{DATA_W{1'b0}}, ax};
    assign sy = {{DATA_W{1'b0}}, ay} * {{DATA_W{1'b0}}, ay};

    assign d2  = {1'b0, sx} + {1'b0, sy};
    assign hit = (d2 <= (2*DATA_W+1)'(R2));

endmodule

// File: rtl/laser_dual_cover.sv
// Two-centre laser coverage search. Loads a 40-point pattern one point per
// clock, then alternately relocates C1 and C2 by scanning every grid
// position, keeping the first position that strictly improves the number of
// points covered by the pair. Pulses DONE for one cycle with the result and
// returns straight to loading the next pattern.
module laser_dual_cover
    import laser_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    state_t              state;
    state_t              state_next;

    // Pattern storage; overwritten every LOAD, so it carries no reset
    point_t              pts [NPTS];

    logic [CNT_W-1:0]    cnt;
    logic [SCAN_W-1:0]   scan;
    logic [PASS_W-1:0]   pass;
    logic                moved;
    logic                prev_idle;

    logic [DATA_W-1:0]   c1x;
    logic [DATA_W-1:0]   c1y;
    logic [DATA_W-1:0]   c2x;
    logic [DATA_W-1:0]   c2y;

    logic [DATA_W-1:0]   cand_x;
    logic [DATA_W-1:0]   cand_y;

    logic [NPTS-1:0]     hit_cand;
    logic [NPTS-1:0]     hit_c1;
    logic [NPTS-1:0]     hit_c2;
    logic [NPTS-1:0]     hit_fixed;

    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  best;

    logic                move_c1;
    logic                replace;
    logic                scan_last;
    logic                pass_idle;
    logic                search_end;
    logic                load_last;

    // Scan order is y outer, x inner: the low nibble of the scan counter is x
    assign cand_x = scan[DATA_W-1:0];
    assign cand_y = scan[SCAN_W-1:DATA_W];

    // Coverage banks: the scanned candidate and both current centres
    for (genvar i = 0; i < NPTS; i++) begin : g_pt
        laser_cover u_cand (
            .cx  (cand_x),
            .cy  (cand_y),
            .px  (pts[i].x),
            .py  (pts[i].y),
            .hit (hit_cand[i])
        );
        laser_cover u_c1 (
            .cx  (c1x),
            .cy  (c1y),
            .px  (pts[i].x),
            .py  (pts[i].y),
            .hit (hit_c1[i])
        );
        laser_cover u_c2 (
            .cx  (c2x),
            .cy  (c2y),
            .px  (pts[i].x),
            .py  (pts[i].y),
            .hit (hit_c2[i])
        );
    end

    // Score the candidate against the fixed centre and decide replacement.
    // The running best always equals the union coverage of the current pair
    // (it starts there and every replacement makes the new pair's union the
    // new best), so it is taken directly from the two centre banks; this also
    // makes it correct on the very first candidate without a setup cycle.
    always_comb begin
        move_c1    = ~pass[0];
        hit_fixed  = move_c1 ? hit_c2 : hit_c1;
        score      = popcount(hit_cand | hit_fixed);
        best       = popcount(hit_c1 | hit_c2);
        replace    = (state == ST_SEARCH) && (score > best);
        scan_last  = (scan == {SCAN_W{1'b1}});
        pass_idle  = ~moved & ~replace;
        search_end = scan_last &&
                     ((pass_idle && prev_idle) || (pass == PASS_W'(MAXPASS - 1)));
        load_last  = (cnt == CNT_W'(NPTS - 1));
    end

    // Next-state logic: LOAD -> SEARCH -> DONE -> LOAD
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:   if (load_last)  state_next = ST_SEARCH;
            ST_SEARCH: if (search_end) state_next = ST_DONE;
            ST_DONE:                   state_next = ST_LOAD;
            default:                   state_next = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Capture one point per clock while loading
    always_ff @(posedge CLK) begin
        if (state == ST_LOAD) begin
            pts[cnt] <= point_t'{x: X, y: Y};
        end
    end

    // Load counter, scan/pass bookkeeping and centre updates
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            scan      <= '0;
            pass      <= '0;
            moved     <= 1'b0;
            prev_idle <= 1'b0;
            c1x       <= '0;
            c1y       <= '0;
            c2x       <= '0;
            c2y       <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    cnt       <= load_last ? '0 : cnt + 1'b1;
                    scan      <= '0;
                    pass      <= '0;
                    moved     <= 1'b0;
                    prev_idle <= 1'b0;
                end
                ST_SEARCH: begin
                    scan <= scan + 1'b1;
                    if (replace) begin
                        if (move_c1) begin
                            c1x <= cand_x;
                            c1y <= cand_y;
                        end else begin
                            c2x <= cand_x;
                            c2y <= cand_y;
                        end
                    end
                    // A pass ends on the last grid position; remember whether it
                    // was idle so two idle passes in a row stop the search
                    if (scan_last) begin
                        pass      <= pass + 1'b1;
                        prev_idle <= pass_idle;
                        moved     <= 1'b0;
                    end else if (replace) begin
                        moved <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign C1X  = c1x;
    assign C1Y  = c1y;
    assign C2X  = c2x;
    assign C2Y  = c2y;
    assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_laser_dual_cover.sv
// Bench for laser_dual_cover: directed patterns, back-to-back operation,
// mid-search reset and random patterns checked against a behavioural model.
module tb_laser_dual_cover;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] X = 4'd0;
    logic [3:0] Y = 4'd0;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       DONE;

    always #5 CLK = ~CLK;

    laser_dual_cover dut (
        .CLK  (CLK),
        .RST  (RST),
        .X    (X),
        .Y    (Y),
        .C1X  (C1X),
        .C1Y  (C1Y),
        .C2X  (C2X),
        .C2Y  (C2Y),
        .DONE (DONE)
    );

    typedef struct {
        logic [3:0] c1x;
        logic [3:0] c1y;
        logic [3:0] c2x;
        logic [3:0] c2y;
    } res_t;

    res_t sb[$];

    int pat_x [40];
    int pat_y [40];
    int m_c1x, m_c1y, m_c2x, m_c2y;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit covers(int cx, int cy, int px, int py);
        return ((cx - px) * (cx - px) + (cy - py) * (cy - py)) <= 16;
    endfunction

    function automatic int union_cov(int ax, int ay, int bx, int by);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            if (covers(ax, ay, pat_x[i], pat_y[i]) || covers(bx, by, pat_x[i], pat_y[i]))
                n++;
        end
        return n;
    endfunction

    // Behavioural search: recompute best at each pass start, scan y outer / x inner
    task automatic model_pattern();
        int best, s;
        bit moved, prev_idle;
        prev_idle = 1'b0;
        for (int p = 0; p < 8; p++) begin
            moved = 1'b0;
            best  = union_cov(m_c1x, m_c1y, m_c2x, m_c2y);
            for (int yy = 0; yy < 16; yy++) begin
                for (int xx = 0; xx < 16; xx++) begin
                    if (p % 2 == 0) s = union_cov(xx, yy, m_c2x, m_c2y);
                    else            s = union_cov(m_c1x, m_c1y, xx, yy);
                    if (s > best) begin
                        best  = s;
                        moved = 1'b1;
                        if (p % 2 == 0) begin m_c1x = xx; m_c1y = yy; end
                        else            begin m_c2x = xx; m_c2y = yy; end
                    end
                end
            end
            if (!moved && prev_idle) break;
            prev_idle = !moved;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0;
        sb.delete();
    endtask

    // Feed pat_x/pat_y, push the expectation, wait for DONE and check it
    task automatic run_pattern(input bit directed, input res_t want, input string tag);
        res_t e;
        int   cycles;
        model_pattern();
        if (directed) begin
            sb.push_back(want);
        end else begin
            e.c1x = 4'(m_c1x); e.c1y = 4'(m_c1y);
            e.c2x = 4'(m_c2x); e.c2y = 4'(m_c2y);
            sb.push_back(e);
        end
        for (int i = 0; i < 40; i++) begin
            X = 4'(pat_x[i]);
            Y = 4'(pat_y[i]);
            n_checks++;
            if (DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL %s load_done_low point %0d: DONE=%b required 0", tag, i, DONE);
            end
            @(negedge CLK);
        end
        cycles = 0;
        while (DONE !== 1'b1 && cycles < 2100) begin
            @(negedge CLK);
            cycles++;
        end
        n_checks++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_timeout: DONE=%b after %0d cycles, required 1", tag, DONE, cycles);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        n_checks++;
        if (cycles > 2052) begin
            n_fail++;
            $display("FAIL %s latency: %0d cycles, required <= 2052", tag, cycles);
        end
        e = sb.pop_front();
        n_checks++;
        if ({C1X, C1Y, C2X, C2Y} !== {e.c1x, e.c1y, e.c2x, e.c2y}) begin
            n_fail++;
            $display("FAIL %s centres: C1=(%0d,%0d) C2=(%0d,%0d) required C1=(%0d,%0d) C2=(%0d,%0d)",
                     tag, C1X, C1Y, C2X, C2Y, e.c1x, e.c1y, e.c2x, e.c2y);
        end
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_one_cycle: DONE=%b one cycle later, required 0", tag, DONE);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({C1X, C1Y, C2X, C2Y, DONE} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: C1=(%0d,%0d) C2=(%0d,%0d) DONE=%b required all 0",
                     C1X, C1Y, C2X, C2Y, DONE);
        end
        RST = 1'b0;
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0;
        sb.delete();
    endtask

    task automatic test_same_point();
        res_t w;
        do_reset();
        for (int i = 0; i < 40; i++) begin pat_x[i] = 3; pat_y[i] = 3; end
        w.c1x = 4'd1; w.c1y = 4'd0; w.c2x = 4'd0; w.c2y = 4'd0;
        run_pattern(1'b1, w, "same_point");
    endtask

    task automatic test_two_clusters();
        res_t w;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            pat_x[i] = (i < 20) ? 2 : 12;
            pat_y[i] = (i < 20) ? 2 : 12;
        end
        w.c1x = 4'd12; w.c1y = 4'd8; w.c2x = 4'd0; w.c2y = 4'd0;
        run_pattern(1'b1, w, "two_clusters");
    endtask

    // Continues from the two-cluster result: (8,8) sits exactly on C1's radius
    task automatic test_back_to_back();
        res_t w;
        for (int i = 0; i < 40; i++) begin pat_x[i] = 8; pat_y[i] = 8; end
        w.c1x = 4'd12; w.c1y = 4'd8; w.c2x = 4'd0; w.c2y = 4'd0;
        run_pattern(1'b1, w, "b2b_edge_radius");
        for (int i = 0; i < 40; i++) begin
            pat_x[i] = $urandom_range(0, 15);
            pat_y[i] = $urandom_range(0, 15);
        end
        run_pattern(1'b0, w, "b2b_random");
    endtask

    task automatic test_reset_mid_search();
        res_t w;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            X = 4'd3; Y = 4'd3;
            @(negedge CLK);
        end
        repeat (20) @(negedge CLK);
        n_checks++;
        if ({C1X, C1Y} !== {4'd1, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_search_progress: C1=(%0d,%0d) required (1,0)", C1X, C1Y);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({C1X, C1Y, C2X, C2Y, DONE} !== 17'd0) begin
            n_fail++;
            $display("FAIL mid_search_reset: C1=(%0d,%0d) C2=(%0d,%0d) DONE=%b required all 0",
                     C1X, C1Y, C2X, C2Y, DONE);
        end
        @(negedge CLK);
        RST = 1'b0;
        m_c1x = 0; m_c1y = 0; m_c2x = 0; m_c2y = 0;
        sb.delete();
        for (int i = 0; i < 40; i++) begin
            pat_x[i] = (i % 2 == 0) ? 5 + $urandom_range(0, 2) : 11 + $urandom_range(0, 3);
            pat_y[i] = (i % 2 == 0) ? 4 + $urandom_range(0, 3) : 10 + $urandom_range(0, 2);
        end
        run_pattern(1'b0, w, "after_reset");
    endtask

    task automatic test_random();
        res_t w;
        int ax, ay, bx, by;
        for (int k = 0; k < 4; k++) begin
            ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
            bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
            for (int i = 0; i < 40; i++) begin
                if (k % 2 == 0) begin
                    pat_x[i] = $urandom_range(0, 15);
                    pat_y[i] = $urandom_range(0, 15);
                end else if (i % 3 == 0) begin
                    pat_x[i] = $urandom_range(0, 15);
                    pat_y[i] = $urandom_range(0, 15);
                end else begin
                    pat_x[i] = ((i % 3 == 1) ? ax : bx) + $urandom_range(0, 4) - 2;
                    pat_y[i] = ((i % 3 == 1) ? ay : by) + $urandom_range(0, 4) - 2;
                    if (pat_x[i] < 0) pat_x[i] = 0;
                    if (pat_x[i] > 15) pat_x[i] = 15;
                    if (pat_y[i] < 0) pat_y[i] = 0;
                    if (pat_y[i] > 15) pat_y[i] = 15;
                end
            end
            run_pattern(1'b0, w, $sformatf("random_%0d", k));
        end
    endtask

    initial begin
        RST = 1'b1;
        test_reset();
        // test_reset releases reset, so start a pattern straight away
        for (int i = 0; i < 40; i++) begin pat_x[i] = 3; pat_y[i] = 3; end
        test_same_point();
        test_two_clusters();
        test_back_to_back();
        test_reset_mid_search();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
